muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit owning the architectural HI/LO registers. It sits beside the single-cycle ALU in the execute stage and replaces that ALU's combinational single-cycle MULT/DIV path with an iterative shift-add multiplier and restoring divider. The unit supports signed/unsigned modes, MTHI/MTLO writes and defined divide-by-zero behaviour, and reports progress through a start/busy/done handshake so the control unit can stall MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_step.sv | 50 +++++
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings presented on muldiv_unit.op
//   - FSM state enum
//   - clog2 helper used to size the iteration counter
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   // Smallest n with 2**n >= value; bounded loop so it elaborates as a constant.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            res = i + 1;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc      : {remainder[WIDTH:0], quotient/dividend[WIDTH-1:0]} for divide,
//              {1'b0, product_hi, multiplier/product_lo} for multiply
//   operand  : divisor (divide) or multiplicand (multiply)
//   acc_next : accumulator after this step (divide: bit 0 left clear)
//   q_bit    : quotient bit produced by a divide step
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH:0]   acc,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH:0]   acc_next,
   output logic               q_bit
);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH+1:0] diff_s;

   // Single iteration: shift-add for multiply, trial subtract for divide.
   always_comb begin
      sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
      // Remainder shifted left with the next dividend bit brought in.
      shifted_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff_s    = {acc[2*WIDTH], shifted_s} - {2'b00, operand};
      acc_next  = acc;
      q_bit     = 1'b0;
      if (is_div) begin
         if (diff_s[WIDTH+1] == 1'b0) begin
            q_bit    = 1'b1;
            acc_next = {diff_s[WIDTH:0], acc[WIDTH-2:0], 1'b0};
         end else begin
            q_bit    = 1'b0;
            acc_next = {shifted_s, acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (acc[0]) begin
            acc_next = {1'b0, sum_s, acc[WIDTH-1:1]};
         end else begin
            acc_next = {2'b00, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, op    : request and operation (muldiv_pkg OP_* codes), taken in IDLE only
//   a, b         : multiplicand/dividend (also MTHI/MTLO source), multiplier/divisor
//   busy         : multiply/divide in progress
//   done         : one-cycle pulse, hi/lo hold the new result
//   div_by_zero  : sticky, set by a divide with b == 0
//   hi, lo       : architectural HI/LO registers
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int               CNT_W    = clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_e             state_r, state_nx_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [2:0]         op_r;
   logic [2*WIDTH:0]   acc_r;
   logic [WIDTH-1:0]   opnd_r;
   logic               neg_q_r, neg_r_r;
   logic               busy_r, done_r, dbz_r;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               busy_nx_s, done_nx_s;

   logic               is_mul_s, is_divop_s, is_signed_s, idle_s;
   logic               go_s, dz_go_s, mthi_go_s, mtlo_go_s, run_div_s;
   logic [WIDTH-1:0]   mag_a_s, mag_b_s;
   logic [2*WIDTH:0]   step_acc_s;
   logic               step_q_s;

   // Request decode and operand magnitudes for the accept edge.
   always_comb begin
      is_mul_s    = (op == OP_MULT) || (op == OP_MULTU);
      is_divop_s  = (op == OP_DIV)  || (op == OP_DIVU);
      is_signed_s = (op == OP_MULT) || (op == OP_DIV);
      idle_s      = (state_r == ST_IDLE);
      go_s        = idle_s && start && (is_mul_s || (is_divop_s && (b != ZERO_W)));
      dz_go_s     = idle_s && start && is_divop_s && (b == ZERO_W);
      mthi_go_s   = idle_s && start && (op == OP_MTHI);
      mtlo_go_s   = idle_s && start && (op == OP_MTLO);
      run_div_s   = (op_r == OP_DIV) || (op_r == OP_DIVU);
      if (is_signed_s && a[WIDTH-1]) begin
         mag_a_s = neg_w(a);
      end else begin
         mag_a_s = a;
      end
      if (is_signed_s && b[WIDTH-1]) begin
         mag_b_s = neg_w(b);
      end else begin
         mag_b_s = b;
      end
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (run_div_s),
      .acc      (acc_r),
      .operand  (opnd_r),
      .acc_next (step_acc_s),
      .q_bit    (step_q_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next state plus the next values of the registered handshake outputs.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (go_s) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_nx_s = ST_FIX;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_FIX:  state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
      busy_nx_s = (state_nx_s != ST_IDLE);
      // A divide by zero completes at its accept edge, so done follows straight away.
      done_nx_s = (state_r == ST_FIX) || dz_go_s;
   end

   // Operand capture, iteration, sign fix-up and HI/LO/flag updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= CNT_ZERO;
         op_r    <= OP_MULT;
         acc_r   <= {(2*WIDTH+1){1'b0}};
         opnd_r  <= ZERO_W;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         dbz_r   <= 1'b0;
         hi_r    <= ZERO_W;
         lo_r    <= ZERO_W;
      end else begin
         busy_r <= busy_nx_s;
         done_r <= done_nx_s;
         case (state_r)
            ST_IDLE: begin
               cnt_r <= CNT_ZERO;
               if (go_s) begin
                  op_r    <= op;
                  // Multiply: multiplier in the low half, multiplicand as operand.
                  // Divide: dividend in the low half, divisor as operand.
                  acc_r   <= {{(WIDTH+1){1'b0}}, (is_mul_s ? mag_b_s : mag_a_s)};
                  opnd_r  <= is_mul_s ? mag_a_s : mag_b_s;
                  neg_q_r <= is_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r_r <= is_signed_s && a[WIDTH-1];
                  if (is_divop_s) begin
                     dbz_r <= 1'b0;
                  end
               end else if (dz_go_s) begin
                  hi_r  <= a;
                  lo_r  <= ONES_W;
                  dbz_r <= 1'b1;
               end else if (mthi_go_s) begin
                  hi_r <= a;
               end else if (mtlo_go_s) begin
                  lo_r <= a;
               end
            end
            ST_RUN: begin
               acc_r <= {step_acc_s[2*WIDTH:1], (run_div_s ? step_q_s : step_acc_s[0])};
               cnt_r <= cnt_r + CNT_ONE;
            end
            ST_FIX: begin
               cnt_r <= CNT_ZERO;
               if (run_div_s) begin
                  lo_r <= neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
                  hi_r <= neg_r_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
               end else begin
                  {hi_r, lo_r} <= neg_q_r ? neg_2w(acc_r[2*WIDTH-1:0]) : acc_r[2*WIDTH-1:0];
               end
            end
            default: cnt_r <= CNT_ZERO;
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign div_by_zero = dbz_r;
   assign hi          = hi_r;
   assign lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH = 32).
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk, rst_n, start;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int tests_run;
   int tests_failed;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called on a falling edge; the next rising edge is the accept edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
      start = 1'b1; op = o; a = va; b = vb;
      @(negedge clk);
      start = 1'b0; a = 32'h0; b = 32'h0;
   endtask

   // Waits (bounded) for done; counts falling edges and busy samples.
   task automatic wait_done(output int cycles, output int busy_cycles);
      cycles = 0; busy_cycles = 0;
      while (done !== 1'b1 && cycles < 100) begin
         if (busy === 1'b1) busy_cycles++;
         @(negedge clk);
         cycles++;
      end
      if (cycles >= 100) $display("FAIL wait_done timeout: no done after %0d cycles", cycles);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
      tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
      tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", hi); end
      tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", lo); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult_signed;
      int c, bc;
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      wait_done(c, bc);
      tests_run++; if (c !== 33) begin tests_failed++; $display("FAIL mult_latency: got %0d expected 33", c); end
      tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
      tests_run++; if (lo !== 32'hFFFF_FFF1) begin tests_failed++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
      @(negedge clk);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_multu_busy;
      int c, bc;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(c, bc);
      tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL multu_busy_at_done: got %b expected 0", busy); end
      tests_run++; if (hi !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
      tests_run++; if (lo !== 32'h0000_0001) begin tests_failed++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
      @(negedge clk);
   endtask

   task automatic test_div;
      int c, bc;
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(c, bc);
      tests_run++; if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
      tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
      @(negedge clk);
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_done(c, bc);
      tests_run++; if (c !== 33) begin tests_failed++; $display("FAIL divu_latency: got %0d expected 33", c); end
      tests_run++; if (lo !== 32'd14) begin tests_failed++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
      tests_run++; if (hi !== 32'd2) begin tests_failed++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
      @(negedge clk);
   endtask

   task automatic test_div_overflow_zero;
      int c, bc;
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(c, bc);
      tests_run++; if (lo !== 32'h8000_0000) begin tests_failed++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
      tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL divovf_hi: got %h expected 00000000", hi); end
      tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL divovf_flag: got %b expected 0", div_by_zero); end
      @(negedge clk);
      issue(OP_DIV, 32'd5, 32'd0);
      tests_run++; if (hi !== 32'd5) begin tests_failed++; $display("FAIL dbz_hi: got %h expected 00000005", hi); end
      tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
      tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL dbz_done: got %b expected 1", done); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL dbz_busy: got %b expected 0", busy); end
      @(negedge clk);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL dbz_done_pulse: got %b expected 0", done); end
      issue(OP_MULTU, 32'd2, 32'd3);
      wait_done(c, bc);
      tests_run++; if (lo !== 32'd6) begin tests_failed++; $display("FAIL dbz_mul_lo: got %h expected 00000006", lo); end
      tests_run++; if (div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dbz_sticky_mul: got %b expected 1", div_by_zero); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int c, bc;
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_done(c, bc);
      tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL b2b_flag_clear: got %b expected 0", div_by_zero); end
      // Accept again on the very cycle done is high.
      issue(OP_DIVU, 32'd9, 32'd3);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got %b expected 1", busy); end
      wait_done(c, bc);
      tests_run++; if (c !== 33) begin tests_failed++; $display("FAIL b2b_latency: got %0d expected 33", c); end
      tests_run++; if (lo !== 32'd3) begin tests_failed++; $display("FAIL b2b_lo: got %h expected 00000003", lo); end
      tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL b2b_hi: got %h expected 00000000", hi); end
      @(negedge clk);
   endtask

   task automatic test_start_while_busy;
      int c, bc;
      issue(OP_MULT, 32'd7, 32'hFFFF_FFFA);
      repeat (9) @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0; a = 32'h0; b = 32'h0;
      tests_run++; if (lo !== 32'd3) begin tests_failed++; $display("FAIL run_lo_hold: got %h expected 00000003", lo); end
      tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL run_hi_hold: got %h expected 00000000", hi); end
      wait_done(c, bc);
      tests_run++; if (c + 10 !== 33) begin tests_failed++; $display("FAIL ignored_latency: got %0d expected 33", c + 10); end
      tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL ignored_hi: got %h expected ffffffff", hi); end
      tests_run++; if (lo !== 32'hFFFF_FFD6) begin tests_failed++; $display("FAIL ignored_lo: got %h expected ffffffd6", lo); end
      @(negedge clk);
      issue(OP_MTLO, 32'h0000_1234, 32'd0);
      tests_run++; if (lo !== 32'h0000_1234) begin tests_failed++; $display("FAIL mtlo_lo: got %h expected 00001234", lo); end
      tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mtlo_hi: got %h expected ffffffff", hi); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mtlo_busy: got %b expected 0", busy); end
      @(negedge clk);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mtlo_done: got %b expected 0", done); end
      issue(3'd7, 32'hDEAD_BEEF, 32'd1);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL badop_busy: got %b expected 0", busy); end
      tests_run++; if (lo !== 32'h0000_1234) begin tests_failed++; $display("FAIL badop_lo: got %h expected 00001234", lo); end
   endtask

   task automatic test_reset_mid_run;
      int c, bc;
      issue(OP_MULT, 32'd11, 32'd13);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done: got %b expected 0", done); end
      tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL midrst_hi: got %h expected 00000000", hi); end
      tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL midrst_lo: got %h expected 00000000", lo); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(OP_DIVU, 32'd9, 32'd3);
      wait_done(c, bc);
      tests_run++; if (lo !== 32'd3) begin tests_failed++; $display("FAIL postrst_lo: got %h expected 00000003", lo); end
      tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL postrst_hi: got %h expected 00000000", hi); end
      @(negedge clk);
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_mult_signed();
      test_multu_busy();
      test_div();
      test_div_overflow_zero();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
